// File: rtl/iterative_divider_if.sv
// Start/busy/done handshake and operand/result bundle for iterative_divider.
interface iterative_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider (DIV/DIVU), one quotient bit per clock.
// Optional macro DIV_EARLY_ZERO_EN: a zero divisor skips the iterations.
module iterative_divider #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  iterative_divider_if.slave  dif
);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  // Operand magnitudes, taken only for signed operations
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  assign a_mag = (dif.is_signed && dif.a[WIDTH-1]) ? -dif.a : dif.a;
  assign b_mag = (dif.is_signed && dif.b[WIDTH-1]) ? -dif.b : dif.b;

  // Shift-in is kept WIDTH+1 wide so large unsigned divisors never lose the top bit
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] rem_diff;
  logic           rem_ge;
  assign rem_shift = {rem, dq[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, divisor};
  assign rem_ge    = (rem_shift >= {1'b0, divisor});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dq          <= '0;
      divisor     <= '0;
      rem         <= '0;
      cnt         <= '0;
      op_signed   <= 1'b0;
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      b_zero      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (dif.start) begin
            op_signed <= dif.is_signed;
            a_neg     <= dif.a[WIDTH-1];
            b_neg     <= dif.b[WIDTH-1];
            b_zero    <= (dif.b == '0);
            dq        <= a_mag;
            divisor   <= b_mag;
            rem       <= '0;
            cnt       <= CNT_W'(WIDTH - 1);
            busy_q    <= 1'b1;
            state     <= ITER;
`ifdef DIV_EARLY_ZERO_EN
            // |A| parked in rem so FIX's sign rule reproduces the raw dividend
            if (dif.b == '0) begin
              rem   <= a_mag;
              state <= FIX;
            end
`endif
          end
        end
        ITER: begin
          dq  <= {dq[WIDTH-2:0], rem_ge};
          rem <= rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        FIX: begin
          if (b_zero) begin
            quotient_q <= '1;
          end else begin
            quotient_q <= (op_signed && (a_neg != b_neg)) ? -dq : dq;
          end
          remainder_q <= (op_signed && a_neg) ? -rem : rem;
          dbz_q       <= b_zero;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dif.busy        = busy_q;
  assign dif.done        = done_q;
  assign dif.quotient    = quotient_q;
  assign dif.remainder   = remainder_q;
  assign dif.div_by_zero = dbz_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed corner cases plus random
// operands against an arithmetic reference model.
module tb_iterative_divider;

  localparam int unsigned WIDTH = 32;
`ifdef DIV_EARLY_ZERO_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk;
  logic rst_n;
  iterative_divider_if #(.WIDTH(WIDTH)) dif ();

  iterative_divider #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dif   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total  = 0;
  int          passed = 0;
  int          edges;
  int          busy_cnt;
  logic [31:0] cur_a;
  logic [31:0] cur_b;
  logic        cur_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Reference: truncating division via wide signed arithmetic
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      z  = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s, input bit imm);
    if (!imm) @(negedge clk);
    cur_a = a; cur_b = b; cur_s = s;
    dif.start = 1'b1; dif.a = a; dif.b = b; dif.is_signed = s;
    @(posedge clk); #1;
    dif.start = 1'b0;
    edges    = 1;
    busy_cnt = dif.busy ? 1 : 0;
  endtask

  // Wait for done (bounded), optionally pulsing a 9/3 start mid-flight, then check
  task automatic finish_op(input string tag, input int inject_at);
    logic [31:0] eq, er;
    logic        ez;
    int          exp_edges;
    int          exp_busy;
    while (!dif.done && edges < 200) begin
      if (edges == inject_at) begin
        dif.start = 1'b1; dif.a = 32'd9; dif.b = 32'd3; dif.is_signed = 1'b0;
      end else begin
        dif.start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
      if (dif.busy) busy_cnt++;
    end
    dif.start = 1'b0;
    chk({tag, "_done_seen"}, 32'(dif.done), 32'd1);
    model(cur_a, cur_b, cur_s, eq, er, ez);
    exp_edges = (EARLY && cur_b == 32'd0) ? 2 : WIDTH + 2;
    exp_busy  = (EARLY && cur_b == 32'd0) ? 1 : WIDTH + 1;
    chk({tag, "_latency"}, 32'(edges), 32'(exp_edges));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    chk({tag, "_quotient"}, dif.quotient, eq);
    chk({tag, "_remainder"}, dif.remainder, er);
    chk({tag, "_dbz"}, 32'(dif.div_by_zero), 32'(ez));
  endtask

  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
    launch(a, b, s, 1'b0);
    finish_op(tag, -1);
  endtask

  initial begin
    logic [31:0] ra, rb, hold_q;
    logic        rs;
    rst_n = 1'b0;
    dif.start = 1'b0; dif.is_signed = 1'b0; dif.a = '0; dif.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(dif.busy), 32'd0);
    chk("rst_done", 32'(dif.done), 32'd0);
    chk("rst_quotient", dif.quotient, 32'd0);
    chk("rst_remainder", dif.remainder, 32'd0);
    chk("rst_dbz", 32'(dif.div_by_zero), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    op("u100_7", 32'd100, 32'd7, 1'b0);
    chk("u100_7_q_lit", dif.quotient, 32'd14);
    chk("u100_7_r_lit", dif.remainder, 32'd2);
    hold_q = dif.quotient;
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(dif.done), 32'd0);
    chk("result_held", dif.quotient, hold_q);

    op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    chk("s_m7_2_q_lit", dif.quotient, 32'hFFFF_FFFD);
    chk("s_m7_2_r_lit", dif.remainder, 32'hFFFF_FFFF);
    op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    chk("s_7_m2_r_lit", dif.remainder, 32'd1);
    op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    chk("s_ovf_q_lit", dif.quotient, 32'h8000_0000);
    op("u_big", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("u_big_r_lit", dif.remainder, 32'h8000_0000);
    op("dbz_u", 32'h1234_5678, 32'd0, 1'b0);
    op("dbz_s", 32'h1234_5678, 32'd0, 1'b1);
    chk("dbz_s_r_lit", dif.remainder, 32'h1234_5678);
    op("dbz_sneg", 32'h8765_4321, 32'd0, 1'b1);

    // Mid-flight start is dropped; a start in the done cycle is taken
    launch(32'd100, 32'd7, 1'b0, 1'b0);
    finish_op("ignored_start", 10);
    chk("ignored_start_q_lit", dif.quotient, 32'd14);
    launch(32'd9, 32'd3, 1'b0, 1'b1);
    finish_op("done_cycle_start", -1);
    chk("done_cycle_start_q_lit", dif.quotient, 32'd3);

    // Asynchronous reset mid-iteration abandons the operation
    launch(32'd100, 32'd7, 1'b0, 1'b0);
    while (edges < 15) begin
      @(posedge clk); #1;
      edges++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(dif.busy), 32'd0);
    chk("mid_rst_quotient", dif.quotient, 32'd0);
    chk("mid_rst_remainder", dif.remainder, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_done", 32'(dif.done), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_done", 32'(dif.done), 32'd0);
    end
    op("u50_5", 32'd50, 32'd5, 1'b0);
    chk("u50_5_q_lit", dif.quotient, 32'd10);

    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(1, 20));
        1: rb = -32'($urandom_range(1, 20));
        2: rb = (n % 8 == 0) ? 32'd0 : rb;
        default: rb = rb >> $urandom_range(0, 28);
      endcase
      op("rand", ra, rb, rs);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
